// File: rtl/udma_eth_tx_framer.sv
// udma_eth_tx_framer
//   Turns 32-bit uDMA TX words into the AXI-Stream byte stream consumed by the
//   MAC transmit path. Words are serialised little-endian (byte 0 = [7:0]).
//   The frame length in bytes is programmed with each start. tlast marks the
//   final byte. An aborted frame ends with a single 0x00 beat that carries
//   tlast and tuser.
//
// Ports
//   clk_int, rst_int      : MAC clock (125 MHz) and asynchronous active-high reset
//   cfg_frame_len_i       : frame length in bytes, sampled with cfg_start_i
//   cfg_start_i           : start pulse (honoured only when idle)
//   cfg_abort_i           : abort pulse (honoured only while a frame is running)
//   data_tx_*             : uDMA word stream (valid/ready)
//   tx_axis_*             : byte stream to the MAC
//   busy_o                : a frame is in progress
//   done_o / aborted_o    : frame-end pulse, with aborted_o when it was aborted
//   err_len_o             : pulse when a start is rejected for a bad length
//   byte_cnt_o            : data bytes handshaken in the current or last frame
module udma_eth_tx_framer #(
   parameter int LEN_WIDTH = 16,
   parameter int MAX_LEN   = 1522
) (
   input  logic                 clk_int,
   input  logic                 rst_int,
   input  logic [LEN_WIDTH-1:0] cfg_frame_len_i,
   input  logic                 cfg_start_i,
   input  logic                 cfg_abort_i,
   input  logic [31:0]          data_tx_i,
   input  logic                 data_tx_valid_i,
   output logic                 data_tx_ready_o,
   output logic [7:0]           tx_axis_tdata,
   output logic                 tx_axis_tvalid,
   input  logic                 tx_axis_tready,
   output logic                 tx_axis_tlast,
   output logic                 tx_axis_tuser,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 aborted_o,
   output logic                 err_len_o,
   output logic [LEN_WIDTH-1:0] byte_cnt_o
);

   localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
   localparam logic [LEN_WIDTH-1:0] ONE_W     = LEN_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, ABORT} state_t;

   state_t               state_reg, state_next;
   logic [LEN_WIDTH-1:0] rem_reg;
   logic [LEN_WIDTH-1:0] byte_cnt_reg;
   logic [1:0]           idx_reg;
   logic [31:0]          word_reg;
   logic                 abort_pend_reg;
   logic                 done_reg;
   logic                 aborted_reg;
   logic                 err_len_reg;

   logic abort_any;
   logic last_beat;
   logic len_ok;
   logic word_hs;

   // An abort seen this cycle acts immediately; one seen during a stalled
   // beat is held in abort_pend_reg until that beat is accepted.
   assign abort_any = cfg_abort_i | abort_pend_reg;
   assign last_beat = (rem_reg == ONE_W);
   assign len_ok    = (cfg_frame_len_i != '0) && (cfg_frame_len_i <= MAX_LEN_W);
   assign word_hs   = data_tx_valid_i & data_tx_ready_o;

   always_comb begin
      state_next      = state_reg;
      data_tx_ready_o = 1'b0;
      tx_axis_tvalid  = 1'b0;
      tx_axis_tdata   = 8'h00;
      tx_axis_tlast   = 1'b0;
      tx_axis_tuser   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cfg_start_i && len_ok) state_next = LOAD;
         end
         LOAD: begin
            // Do not swallow a word that would never be sent.
            data_tx_ready_o = ~abort_any;
            if (abort_any)            state_next = ABORT;
            else if (data_tx_valid_i) state_next = SEND;
         end
         SEND: begin
            tx_axis_tvalid = 1'b1;
            tx_axis_tdata  = word_reg[{idx_reg, 3'b000} +: 8];
            tx_axis_tlast  = last_beat;
            if (tx_axis_tready) begin
               if (last_beat) begin
                  state_next = IDLE;
               end else if (abort_any) begin
                  state_next = ABORT;
               end else if (idx_reg == 2'd3) begin
                  // Prefetch the next word in the same cycle so the byte
                  // stream continues without a bubble.
                  data_tx_ready_o = 1'b1;
                  if (!data_tx_valid_i) state_next = LOAD;
               end
            end
         end
         ABORT: begin
            tx_axis_tvalid = 1'b1;
            tx_axis_tlast  = 1'b1;
            tx_axis_tuser  = 1'b1;
            if (tx_axis_tready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_int or posedge rst_int) begin
      if (rst_int) begin
         state_reg      <= IDLE;
         rem_reg        <= '0;
         byte_cnt_reg   <= '0;
         idx_reg        <= 2'd0;
         word_reg       <= 32'h0;
         abort_pend_reg <= 1'b0;
         done_reg       <= 1'b0;
         aborted_reg    <= 1'b0;
         err_len_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
         err_len_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               abort_pend_reg <= 1'b0;
               if (cfg_start_i) begin
                  if (len_ok) begin
                     rem_reg      <= cfg_frame_len_i;
                     byte_cnt_reg <= '0;
                     idx_reg      <= 2'd0;
                  end else begin
                     err_len_reg <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (word_hs) begin
                  word_reg <= data_tx_i;
                  idx_reg  <= 2'd0;
               end
            end
            SEND: begin
               if (cfg_abort_i) abort_pend_reg <= 1'b1;
               if (tx_axis_tready) begin
                  rem_reg      <= rem_reg - ONE_W;
                  byte_cnt_reg <= byte_cnt_reg + ONE_W;
                  // Wraps to 0 after byte 3, which is where the next word starts.
                  idx_reg      <= idx_reg + 2'd1;
                  if (last_beat) begin
                     done_reg       <= 1'b1;
                     abort_pend_reg <= 1'b0;   // frame finished normally
                  end else if (abort_any) begin
                     abort_pend_reg <= 1'b0;
                  end else if (word_hs) begin
                     word_reg <= data_tx_i;
                  end
               end
            end
            ABORT: begin
               abort_pend_reg <= 1'b0;
               if (tx_axis_tready) begin
                  done_reg    <= 1'b1;
                  aborted_reg <= 1'b1;
               end
            end
            default: abort_pend_reg <= 1'b0;
         endcase
      end
   end

   assign busy_o     = (state_reg != IDLE);
   assign done_o     = done_reg;
   assign aborted_o  = aborted_reg;
   assign err_len_o  = err_len_reg;
   assign byte_cnt_o = byte_cnt_reg;

endmodule

// File: tb/tb_udma_eth_tx_framer.sv
// Testbench for udma_eth_tx_framer. Each frame's expected byte stream and
// frame-end record are computed from the frame length, source words and abort
// point, then queued; an independent monitor pops and compares on every
// handshake and on every done_o pulse.
module tb_udma_eth_tx_framer;

   localparam int LEN_WIDTH = 16;
   localparam int MAX_LEN   = 1522;

   logic                 clk_int         = 1'b0;
   logic                 rst_int         = 1'b1;
   logic [LEN_WIDTH-1:0] cfg_frame_len_i = '0;
   logic                 cfg_start_i     = 1'b0;
   logic                 cfg_abort_i     = 1'b0;
   logic [31:0]          data_tx_i       = 32'h0;
   logic                 data_tx_valid_i = 1'b0;
   logic                 data_tx_ready_o;
   logic [7:0]           tx_axis_tdata;
   logic                 tx_axis_tvalid;
   logic                 tx_axis_tready  = 1'b0;
   logic                 tx_axis_tlast;
   logic                 tx_axis_tuser;
   logic                 busy_o;
   logic                 done_o;
   logic                 aborted_o;
   logic                 err_len_o;
   logic [LEN_WIDTH-1:0] byte_cnt_o;

   udma_eth_tx_framer #(.LEN_WIDTH(LEN_WIDTH), .MAX_LEN(MAX_LEN)) dut (
      .clk_int         (clk_int),
      .rst_int         (rst_int),
      .cfg_frame_len_i (cfg_frame_len_i),
      .cfg_start_i     (cfg_start_i),
      .cfg_abort_i     (cfg_abort_i),
      .data_tx_i       (data_tx_i),
      .data_tx_valid_i (data_tx_valid_i),
      .data_tx_ready_o (data_tx_ready_o),
      .tx_axis_tdata   (tx_axis_tdata),
      .tx_axis_tvalid  (tx_axis_tvalid),
      .tx_axis_tready  (tx_axis_tready),
      .tx_axis_tlast   (tx_axis_tlast),
      .tx_axis_tuser   (tx_axis_tuser),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .aborted_o       (aborted_o),
      .err_len_o       (err_len_o),
      .byte_cnt_o      (byte_cnt_o)
   );

   always #4 clk_int = ~clk_int;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   typedef struct packed {
      logic                 aborted;
      logic [LEN_WIDTH-1:0] cnt;
   } fend_t;

   beat_t       exp_beats[$];
   fend_t       exp_ends[$];
   logic [31:0] src_words[$];

   int checks = 0;
   int errors = 0;
   int beats_seen = 0;
   int frames_done = 0;
   int err_seen = 0;
   int cyc = 0;
   int first_beat_cyc = -1;
   int last_beat_cyc = -1;
   int src_idx = 0;
   bit rand_valid = 1'b0;
   int tready_mode = 0;   // 0: always ready, 1: toggle, 2: random

   always @(posedge clk_int) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // MAC side ready pattern.
   initial forever begin
      @(negedge clk_int);
      case (tready_mode)
         0:       tx_axis_tready = 1'b1;
         1:       tx_axis_tready = ~tx_axis_tready;
         default: tx_axis_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // uDMA word source: presents src_words in order, optionally with gaps.
   initial forever begin
      @(negedge clk_int);
      if (src_idx < src_words.size() && (!rand_valid || $urandom_range(0, 2) != 0)) begin
         data_tx_valid_i = 1'b1;
         data_tx_i       = src_words[src_idx];
      end else begin
         data_tx_valid_i = 1'b0;
         data_tx_i       = $urandom;
      end
      #1;
      if (data_tx_valid_i && data_tx_ready_o && !rst_int) src_idx++;
   end

   // Monitor: samples just after the falling edge, i.e. the values that the
   // next rising edge will act on.
   beat_t      mon_b;
   fend_t      mon_f;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_bits  = '0;
   initial forever begin
      @(negedge clk_int);
      #2;
      if (rst_int) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_tvalid", 32'(tx_axis_tvalid), 32'd1);
            check("hold_beat", 32'({tx_axis_tdata, tx_axis_tlast, tx_axis_tuser}), 32'(prev_bits));
         end
         if (tx_axis_tvalid)
            check("tuser_only_with_tlast", 32'(tx_axis_tuser & ~tx_axis_tlast), 32'd0);
         if (tx_axis_tvalid && tx_axis_tready) begin
            if (exp_beats.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got tdata=0x%02h tlast=%0b, expected no beat", tx_axis_tdata, tx_axis_tlast);
            end else begin
               mon_b = exp_beats.pop_front();
               check("tdata", 32'(tx_axis_tdata), 32'(mon_b.data));
               check("tlast", 32'(tx_axis_tlast), 32'(mon_b.last));
               check("tuser", 32'(tx_axis_tuser), 32'(mon_b.user));
            end
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            beats_seen++;
         end
         prev_stall = tx_axis_tvalid && !tx_axis_tready;
         prev_bits  = {tx_axis_tdata, tx_axis_tlast, tx_axis_tuser};
         if (done_o) begin
            if (exp_ends.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done_o=1, expected no frame end");
            end else begin
               mon_f = exp_ends.pop_front();
               check("aborted_o", 32'(aborted_o), 32'(mon_f.aborted));
               check("byte_cnt_o", 32'(byte_cnt_o), 32'(mon_f.cnt));
               check("busy_after_done", 32'(busy_o), 32'd0);
            end
            frames_done++;
         end
         if (aborted_o) check("aborted_needs_done", 32'(done_o), 32'd1);
         if (err_len_o) err_seen++;
      end
   end

   task automatic fill_random(input int len);
      src_words.delete();
      for (int i = 0; i < (len + 3) / 4; i++) src_words.push_back($urandom);
      src_idx = 0;
   endtask

   // Reference model: bytes are the little-endian flattening of the words,
   // truncated to len. An abort noticed after k accepted bytes lets byte k+1
   // finish and then appends the 0x00 tlast/tuser beat, unless byte k+1 was
   // already the last byte, in which case the frame ends normally.
   task automatic prepare(input int len, input int abort_after);
      int          nbytes;
      bit          ab;
      logic [31:0] w;
      beat_t       b;
      fend_t       f;
      ab     = (abort_after >= 1) && (abort_after + 1 < len);
      nbytes = ab ? abort_after + 1 : len;
      for (int i = 0; i < nbytes; i++) begin
         w      = src_words[i / 4];
         b.data = 8'(w >> (8 * (i % 4)));
         b.last = !ab && (i == len - 1);
         b.user = 1'b0;
         exp_beats.push_back(b);
      end
      if (ab) begin
         b.data = 8'h00;
         b.last = 1'b1;
         b.user = 1'b1;
         exp_beats.push_back(b);
      end
      f.aborted = ab;
      f.cnt     = LEN_WIDTH'(nbytes);
      exp_ends.push_back(f);
   endtask

   task automatic pulse_start(input int len, input bit with_abort);
      @(negedge clk_int);
      cfg_frame_len_i = LEN_WIDTH'(len);
      cfg_start_i     = 1'b1;
      cfg_abort_i     = with_abort;
      @(negedge clk_int);
      cfg_start_i     = 1'b0;
      cfg_abort_i     = 1'b0;
   endtask

   task automatic run_frame(input int len, input int abort_after, input bit start_with_abort);
      int base_beats;
      int base_done;
      int guard;
      base_beats = beats_seen;
      base_done  = frames_done;
      prepare(len, abort_after);
      first_beat_cyc = -1;
      pulse_start(len, start_with_abort);
      if (abort_after >= 1) begin
         guard = 0;
         while (beats_seen - base_beats < abort_after && guard < 5000) begin
            @(negedge clk_int);
            guard++;
         end
         cfg_abort_i = 1'b1;
         @(negedge clk_int);
         cfg_abort_i = 1'b0;
      end
      guard = 0;
      while (frames_done == base_done && guard < 5000) begin
         @(negedge clk_int);
         guard++;
      end
      #1;
      check("frame_completes", 32'(frames_done - base_done), 32'd1);
      check("scoreboard_drained", 32'(exp_beats.size() + exp_ends.size()), 32'd0);
      check("idle_quiet", 32'({data_tx_ready_o, tx_axis_tvalid, busy_o}), 32'd0);
      if (abort_after == 0)
         check("words_consumed", 32'(src_idx), 32'((len + 3) / 4));
      $display("frame len=%0d abort_after=%0d start_abort=%0b tready_mode=%0d gaps=%0b", len, abort_after,
               start_with_abort, tready_mode, rand_valid);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   int len_r;
   int ab_r;
   bit sa_r;
   int base_e;
   int base_b;
   int guard_m;

   initial begin
      tready_mode = 0;
      rand_valid  = 1'b0;
      repeat (3) @(negedge clk_int);
      #1;
      check("reset_outputs", 32'({data_tx_ready_o, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser,
                                  busy_o, done_o, aborted_o, err_len_o, byte_cnt_o}), 32'd0);
      @(negedge clk_int);
      rst_int = 1'b0;
      repeat (2) @(negedge clk_int);

      // Two full words, back to back, no bubble between bytes.
      src_words = '{32'h44332211, 32'h88776655};
      src_idx   = 0;
      run_frame(8, 0, 1'b0);
      check("no_gap_len8", 32'(last_beat_cyc - first_beat_cyc), 32'd7);

      // Partial last word: bytes 1..3 of the second word are dropped.
      src_words = '{32'hDDCCBBAA, 32'h000000EE};
      src_idx   = 0;
      run_frame(5, 0, 1'b0);

      // Back-pressure every other cycle.
      tready_mode = 1;
      fill_random(6);
      run_frame(6, 0, 1'b0);

      // Abort after 10 handshakes: byte 11 finishes, then the abort beat.
      tready_mode = 0;
      fill_random(64);
      run_frame(64, 10, 1'b0);

      // Abort landing on the final byte is dropped.
      tready_mode = 2;
      fill_random(9);
      run_frame(9, 8, 1'b0);

      // Length limits.
      tready_mode = 0;
      fill_random(1);
      run_frame(1, 0, 1'b0);
      fill_random(MAX_LEN);
      run_frame(MAX_LEN, 0, 1'b0);

      // Rejected lengths.
      base_e = err_seen;
      base_b = beats_seen;
      src_words.delete();
      src_idx = 0;
      pulse_start(0, 1'b0);
      repeat (2) @(negedge clk_int);
      pulse_start(MAX_LEN + 1, 1'b0);
      repeat (3) @(negedge clk_int);
      #1;
      check("err_len_pulses", 32'(err_seen - base_e), 32'd2);
      check("err_busy", 32'(busy_o), 32'd0);
      check("err_no_beats", 32'(beats_seen - base_b), 32'd0);
      $display("rejected starts len=0 and len=%0d", MAX_LEN + 1);

      // Reset in the middle of a 20-byte frame.
      fill_random(20);
      prepare(20, 0);
      base_b = beats_seen;
      pulse_start(20, 1'b0);
      guard_m = 0;
      while (beats_seen - base_b < 3 && guard_m < 1000) begin
         @(negedge clk_int);
         guard_m++;
      end
      rst_int = 1'b1;
      #1;
      check("midframe_reset_outputs", 32'({data_tx_ready_o, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast,
                                           tx_axis_tuser, busy_o, done_o, aborted_o, err_len_o, byte_cnt_o}), 32'd0);
      exp_beats.delete();
      exp_ends.delete();
      src_words.delete();
      src_idx = 0;
      @(negedge clk_int);
      rst_int = 1'b0;
      $display("reset applied mid-frame after %0d bytes", beats_seen - base_b);
      fill_random(4);
      run_frame(4, 0, 1'b0);

      // Start and abort together in idle: the frame runs normally.
      fill_random(7);
      run_frame(7, 0, 1'b1);

      // Randomised frames.
      for (int n = 0; n < 30; n++) begin
         len_r       = $urandom_range(1, 40);
         tready_mode = $urandom_range(0, 2);
         rand_valid  = 1'($urandom_range(0, 1));
         sa_r        = ($urandom_range(0, 4) == 0);
         ab_r        = 0;
         if (!rand_valid && len_r >= 2 && $urandom_range(0, 2) == 0)
            ab_r = $urandom_range(1, len_r - 1);
         fill_random(len_r);
         run_frame(len_r, ab_r, sa_r);
         repeat ($urandom_range(0, 3)) @(negedge clk_int);
      end

      repeat (5) @(negedge clk_int);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
